// File: rtl/execute_ctrl.sv
// Y86-64 execute-stage control: ALU operand/function select, condition codes,
// cmov/jXX evaluation, E->M pipeline register and a halt FSM that freezes CC.
module execute_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_icode,
    input  logic [3:0]  E_ifun,
    input  logic [2:0]  E_stat,
    input  logic [63:0] E_valA,
    input  logic [63:0] E_valB,
    input  logic [63:0] E_valC,
    input  logic [3:0]  E_dstE,
    input  logic [3:0]  E_dstM,
    output logic [63:0] alu_a,
    output logic [63:0] alu_b,
    output logic [1:0]  alu_fun,
    input  logic [63:0] alu_res,
    input  logic        alu_zf,
    input  logic        alu_sf,
    input  logic        alu_of,
    input  logic [2:0]  m_stat,
    input  logic [2:0]  W_stat,
    input  logic        M_stall,
    input  logic        M_bubble,
    output logic        cc_zf,
    output logic        cc_sf,
    output logic        cc_of,
    output logic        e_cnd,
    output logic [3:0]  e_dstE,
    output logic [3:0]  M_icode,
    output logic [2:0]  M_stat,
    output logic        M_cnd,
    output logic [63:0] M_valE,
    output logic [63:0] M_valA,
    output logic [3:0]  M_dstE,
    output logic [3:0]  M_dstM,
    output logic        halted
);

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [3:0] INOP     = 4'h1;

    typedef enum logic {StRun, StHalted} state_e;

    state_e state_q, state_d;
    logic   zf_q, sf_q, of_q;
    logic   cond, lt, set_cc, m_load;

    always_comb begin
        alu_a = '0;
        case (E_icode)
            4'h2, 4'h6:       alu_a = E_valA;
            4'h3, 4'h4, 4'h5: alu_a = E_valC;
            4'h8, 4'hA:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
            4'h9, 4'hB:       alu_a = 64'd8;
            default:          alu_a = '0;
        endcase
    end

    always_comb begin
        alu_b = '0;
        case (E_icode)
            4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: alu_b = E_valB;
            default:                                  alu_b = '0;
        endcase
    end

    assign alu_fun = (E_icode == 4'h6) ? E_ifun[1:0] : 2'd0;

    // Conditions read the registered CC, never the in-flight ALU flags.
    assign lt = sf_q ^ of_q;
    always_comb begin
        cond = 1'b0;
        case (E_ifun)
            4'h0:    cond = 1'b1;
            4'h1:    cond = lt | zf_q;
            4'h2:    cond = lt;
            4'h3:    cond = zf_q;
            4'h4:    cond = ~zf_q;
            4'h5:    cond = ~lt;
            4'h6:    cond = ~lt & ~zf_q;
            default: cond = 1'b0;
        endcase
    end

    assign e_cnd  = ((E_icode == 4'h2) || (E_icode == 4'h7)) ? cond : 1'b0;
    assign e_dstE = ((E_icode == 4'h2) && !e_cnd) ? RNONE : E_dstE;

    assign halted = (state_q == StHalted);
    assign set_cc = (E_icode == 4'h6) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK)
                    && !M_stall && !halted;
    assign m_load = !M_stall && !M_bubble;

    always_ff @(posedge clk) begin
        if (reset) begin
            zf_q <= 1'b1;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (set_cc) begin
            zf_q <= alu_zf;
            sf_q <= alu_sf;
            of_q <= alu_of;
        end
    end

    assign cc_zf = zf_q;
    assign cc_sf = sf_q;
    assign cc_of = of_q;

    // Stall outranks bubble; reset outranks both.
    always_ff @(posedge clk) begin
        if (reset || (!M_stall && M_bubble)) begin
            M_icode <= INOP;
            M_stat  <= STAT_AOK;
            M_cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (m_load) begin
            M_icode <= E_icode;
            M_stat  <= E_stat;
            M_cnd   <= e_cnd;
            M_valE  <= alu_res;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == StRun) && m_load && (E_stat != STAT_AOK)) begin
            state_d = StHalted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: tb/tb_execute_ctrl.sv
// Randomized + directed bench for execute_ctrl; a reference model pushes expected
// results to a scoreboard queue and a monitor process compares each cycle.
module tb_execute_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
    logic [2:0]  E_stat, m_stat, W_stat;
    logic [63:0] E_valA, E_valB, E_valC, alu_res;
    logic        alu_zf, alu_sf, alu_of, M_stall, M_bubble;
    logic [63:0] alu_a, alu_b, M_valE, M_valA;
    logic [1:0]  alu_fun;
    logic        cc_zf, cc_sf, cc_of, e_cnd, M_cnd, halted;
    logic [3:0]  e_dstE, M_icode, M_dstE, M_dstM;
    logic [2:0]  M_stat;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    execute_ctrl dut (
        .clk(clk), .reset(reset),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_stat(E_stat),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
        .alu_res(alu_res), .alu_zf(alu_zf), .alu_sf(alu_sf), .alu_of(alu_of),
        .m_stat(m_stat), .W_stat(W_stat), .M_stall(M_stall), .M_bubble(M_bubble),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of),
        .e_cnd(e_cnd), .e_dstE(e_dstE),
        .M_icode(M_icode), .M_stat(M_stat), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM), .halted(halted)
    );

    typedef struct {
        logic [63:0] a, b;
        logic [1:0]  fun;
        logic        cnd;
        logic [3:0]  dste;
        logic        zf, sf, of, halt;
        logic [3:0]  m_icode;
        logic [2:0]  m_stat;
        logic        m_cnd;
        logic [63:0] m_vale, m_vala;
        logic [3:0]  m_dste, m_dstm;
    } exp_t;

    exp_t sb[$];

    // Reference model state (architectural view)
    logic        mzf, msf, mof, mhalt;
    logic [3:0]  mm_icode, mm_dste, mm_dstm;
    logic [2:0]  mm_stat;
    logic        mm_cnd;
    logic [63:0] mm_vale, mm_vala;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        {mzf, msf, mof} = 3'b100;
        mhalt    = 1'b0;
        mm_icode = 4'h1; mm_stat = 3'd1; mm_cnd = 1'b0;
        mm_vale  = '0;   mm_vala = '0;   mm_dste = 4'hF; mm_dstm = 4'hF;
    endtask

    // Apply current inputs, predict this cycle's outputs and the post-edge state.
    task automatic cycle();
        exp_t e;
        logic [63:0] a, b, r;
        logic [1:0]  f;
        logic        zf, sf, of, lt, cond, cnd, setcc;
        logic [3:0]  dste;
        if (E_icode == 4'h2 || E_icode == 4'h6)      a = E_valA;
        else if (E_icode >= 4'h3 && E_icode <= 4'h5) a = E_valC;
        else if (E_icode == 4'h8 || E_icode == 4'hA) a = -64'sd8;
        else if (E_icode == 4'h9 || E_icode == 4'hB) a = 64'd8;
        else                                         a = 64'd0;
        b = (E_icode >= 4'h4 && E_icode <= 4'hB && E_icode != 4'h7) ? E_valB : 64'd0;
        f = (E_icode == 4'h6) ? E_ifun[1:0] : 2'd0;
        of = 1'b0;
        case (f)
            2'd0: begin r = b + a; of = (a[63] == b[63]) && (r[63] != a[63]); end
            2'd1: begin r = b - a; of = (a[63] != b[63]) && (r[63] != b[63]); end
            2'd2: r = b & a;
            default: r = b ^ a;
        endcase
        zf = (r == 64'd0);
        sf = r[63];
        alu_res = r; alu_zf = zf; alu_sf = sf; alu_of = of;

        lt = msf ^ mof;
        case (E_ifun)
            4'h0: cond = 1'b1;
            4'h1: cond = lt || mzf;
            4'h2: cond = lt;
            4'h3: cond = mzf;
            4'h4: cond = !mzf;
            4'h5: cond = !lt;
            4'h6: cond = !lt && !mzf;
            default: cond = 1'b0;
        endcase
        cnd  = (E_icode == 4'h2 || E_icode == 4'h7) && cond;
        dste = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
        e.a = a; e.b = b; e.fun = f; e.cnd = cnd; e.dste = dste;

        if (reset) begin
            model_reset();
        end else begin
            setcc = (E_icode == 4'h6) && m_stat == 3'd1 && W_stat == 3'd1 && !M_stall && !mhalt;
            if (setcc) {mzf, msf, mof} = {zf, sf, of};
            if (!M_stall && M_bubble) begin
                mm_icode = 4'h1; mm_stat = 3'd1; mm_cnd = 1'b0;
                mm_vale  = '0;   mm_vala = '0;   mm_dste = 4'hF; mm_dstm = 4'hF;
            end else if (!M_stall) begin
                mm_icode = E_icode; mm_stat = E_stat; mm_cnd = cnd;
                mm_vale  = r; mm_vala = E_valA; mm_dste = dste; mm_dstm = E_dstM;
                if (E_stat != 3'd1) mhalt = 1'b1;
            end
        end
        e.zf = mzf; e.sf = msf; e.of = mof; e.halt = mhalt;
        e.m_icode = mm_icode; e.m_stat = mm_stat; e.m_cnd = mm_cnd;
        e.m_vale = mm_vale; e.m_vala = mm_vala; e.m_dste = mm_dste; e.m_dstm = mm_dstm;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic set_e(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] va,
                         input logic [63:0] vb, input logic [63:0] vc, input logic [3:0] de,
                         input logic [2:0] st);
        E_icode = ic; E_ifun = fn; E_valA = va; E_valB = vb; E_valC = vc;
        E_dstE = de; E_dstM = 4'hF; E_stat = st;
        reset = 1'b0; m_stat = 3'd1; W_stat = 3'd1; M_stall = 1'b0; M_bubble = 1'b0;
    endtask

    function automatic logic [63:0] pick64();
        logic [63:0] s;
        s = 64'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: return s;
            1: return -s;
            2: return {$urandom(), $urandom()};
            default: return 64'h8000_0000_0000_0000 ^ s;
        endcase
    endfunction

    // Monitor: combinational outputs mid-cycle, registered state just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("alu_a", alu_a, e.a);
                chk("alu_b", alu_b, e.b);
                chk("alu_fun", 64'(alu_fun), 64'(e.fun));
                chk("e_cnd", 64'(e_cnd), 64'(e.cnd));
                chk("e_dstE", 64'(e_dstE), 64'(e.dste));
                @(posedge clk);
                #1;
                chk("cc", 64'({cc_zf, cc_sf, cc_of}), 64'({e.zf, e.sf, e.of}));
                chk("halted", 64'(halted), 64'(e.halt));
                chk("M_icode", 64'(M_icode), 64'(e.m_icode));
                chk("M_stat", 64'(M_stat), 64'(e.m_stat));
                chk("M_cnd", 64'(M_cnd), 64'(e.m_cnd));
                chk("M_valE", M_valE, e.m_vale);
                chk("M_valA", M_valA, e.m_vala);
                chk("M_dstE", 64'(M_dstE), 64'(e.m_dste));
                chk("M_dstM", 64'(M_dstM), 64'(e.m_dstm));
            end
        end
    end

    initial begin
        set_e(4'h1, 4'h0, '0, '0, '0, 4'hF, 3'd1);
        alu_res = '0; alu_zf = 1'b0; alu_sf = 1'b0; alu_of = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("rst_cc", 64'({cc_zf, cc_sf, cc_of}), 64'(3'b100));
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_M_icode", 64'(M_icode), 64'h1);
        chk("rst_M_dst", 64'({M_dstE, M_dstM}), 64'hFF);
        model_reset();

        // OPq add 5 + -5 sets ZF
        set_e(4'h6, 4'h0, 64'd5, -64'sd5, '0, 4'h2, 3'd1); cycle();
        // sub 0-1 -> SF=1,ZF=0, then cmovle taken
        set_e(4'h6, 4'h1, 64'd1, 64'd0, '0, 4'h2, 3'd1); cycle();
        set_e(4'h2, 4'h1, 64'd7, '0, '0, 4'h3, 3'd1); cycle();
        // add 1+1 -> SF=0,ZF=0, cmovle not taken
        set_e(4'h6, 4'h0, 64'd1, 64'd1, '0, 4'h2, 3'd1); cycle();
        set_e(4'h2, 4'h1, 64'd7, '0, '0, 4'h3, 3'd1); cycle();
        // pushq / ret / irmovq operand selection
        set_e(4'hA, 4'h0, 64'd9, 64'h100, '0, 4'h4, 3'd1); cycle();
        set_e(4'h9, 4'h0, 64'd0, 64'h200, '0, 4'h4, 3'd1); cycle();
        set_e(4'h3, 4'h0, 64'd0, 64'd0, 64'h1234, 4'h5, 3'd1); cycle();
        // exceptional m/W status blocks CC update
        set_e(4'h6, 4'h1, 64'd1, 64'd0, '0, 4'h2, 3'd1); m_stat = 3'd3; cycle();
        set_e(4'h6, 4'h1, 64'd1, 64'd0, '0, 4'h2, 3'd1); W_stat = 3'd2; cycle();
        // HLT reaches M -> halted, CC frozen, reset clears
        set_e(4'h0, 4'h0, '0, '0, '0, 4'hF, 3'd2); cycle();
        set_e(4'h6, 4'h1, 64'd1, 64'd0, '0, 4'h2, 3'd1); cycle();
        set_e(4'h7, 4'h3, '0, '0, 64'h40, 4'hF, 3'd1); cycle();
        set_e(4'h1, 4'h0, '0, '0, '0, 4'hF, 3'd1); reset = 1'b1; cycle();
        // stall beats bubble; bubble alone; stalled INS does not halt until loaded
        set_e(4'h6, 4'h0, 64'd3, 64'd4, '0, 4'h1, 3'd1); cycle();
        set_e(4'h6, 4'h0, 64'd1, 64'd0, '0, 4'h1, 3'd1); M_stall = 1'b1; M_bubble = 1'b1; cycle();
        set_e(4'h6, 4'h0, 64'd1, 64'd0, '0, 4'h1, 3'd1); M_bubble = 1'b1; cycle();
        set_e(4'h5, 4'h0, 64'd2, 64'd8, 64'h10, 4'hF, 3'd4); M_stall = 1'b1; cycle();
        set_e(4'h5, 4'h0, 64'd2, 64'd8, 64'h10, 4'hF, 3'd4); cycle();
        set_e(4'h1, 4'h0, '0, '0, '0, 4'hF, 3'd1); reset = 1'b1; cycle();

        for (int i = 0; i < 400; i++) begin
            logic [3:0] ic;
            ic = ($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 11));
            set_e(ic, (ic == 4'h6) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 9)),
                  pick64(), pick64(), pick64(), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1);
            E_dstM   = 4'($urandom_range(0, 15));
            m_stat   = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'd1;
            W_stat   = ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd1;
            M_stall  = ($urandom_range(0, 7) == 0);
            M_bubble = ($urandom_range(0, 7) == 0);
            reset    = ($urandom_range(0, 39) == 0);
            cycle();
        end

        repeat (3) @(posedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
